// File: rtl/add_arbiter.sv
// Round-robin scheduler sharing one self-timed adder among M clocked requesters.
// Define ADD_ARB_TIMEOUT_EN to bound WAIT with a TIMEOUT counter and a sticky fault.
module add_arbiter #(
    parameter int N       = 32,
    parameter int M       = 4,
    parameter int TIMEOUT = 255,
    localparam int IW     = (M > 1) ? $clog2(M) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [M-1:0]    in_valid,
    output logic [M-1:0]    in_ready,
    input  logic [M*N-1:0]  in_x,
    input  logic [M*N-1:0]  in_y,
    input  logic [M-1:0]    in_cin,
    output logic            out_valid,
    output logic [IW-1:0]   out_id,
    output logic [N-1:0]    out_sum,
    output logic            out_cout,
    output logic            out_err,
    output logic            fault,
    output logic            add_req,
    input  logic            add_fin,
    output logic [N-1:0]    add_x,
    output logic [N-1:0]    add_y,
    output logic            add_cin,
    input  logic [N-1:0]    add_so,
    input  logic            add_couto
);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_BLIND, S_WAIT, S_DONE, S_FAULT
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, cur_id, gnt_id;
    logic            gnt_vld, accept, tmo;
    logic [IW:0]     idx;
    logic [1:0]      blind_cnt;
    logic            fin_s1, fin_s;
    logic [M-1:0]    one_hot;

    // The adder is never reset, so the synchronizer simply tracks add_fin.
    always_ff @(posedge clk) begin
        fin_s1 <= add_fin;
        fin_s  <= fin_s1;
    end

    // Later loop iterations are closer to ptr, so the nearest requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = M - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(M)) idx = idx - (IW+1)'(M);
            if (in_valid[idx[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx[IW-1:0];
            end
        end
    end

    // fin_s high in IDLE means the adder has drained any earlier operation.
    assign accept = (state == S_IDLE) && fin_s && gnt_vld;

    always_comb begin
        one_hot         = '0;
        one_hot[gnt_id] = accept;
    end
    assign in_ready = one_hot;

`ifdef ADD_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    assign tmo = (state == S_WAIT) && !fin_s && (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign tmo     = 1'b0;
    assign out_err = 1'b0;
    assign fault   = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: state_nxt = S_BLIND;
            S_BLIND: if (blind_cnt == 2'd2) state_nxt = S_WAIT;
            S_WAIT:  if (fin_s || tmo) state_nxt = S_DONE;
`ifdef ADD_ARB_TIMEOUT_EN
            S_DONE:  state_nxt = out_err ? S_FAULT : S_IDLE;
`else
            S_DONE:  state_nxt = S_IDLE;
`endif
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur_id    <= '0;
            blind_cnt <= '0;
            add_req   <= 1'b0;
            add_x     <= '0;
            add_y     <= '0;
            add_cin   <= 1'b0;
            out_valid <= 1'b0;
            out_id    <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
`ifdef ADD_ARB_TIMEOUT_EN
            wait_cnt  <= '0;
            out_err   <= 1'b0;
            fault     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            out_valid <= 1'b0;
            if (accept) begin
                add_x   <= in_x[gnt_id*N +: N];
                add_y   <= in_y[gnt_id*N +: N];
                add_cin <= in_cin[gnt_id];
                cur_id  <= gnt_id;
                ptr     <= (gnt_id == IW'(M - 1)) ? '0 : gnt_id + 1'b1;
            end
            if (state == S_SETUP) begin
                add_req   <= 1'b1;
                blind_cnt <= '0;
            end
            if (state == S_BLIND) blind_cnt <= blind_cnt + 2'd1;
            // Results are registered on the way into DONE so the strobe lands in DONE.
            if (state == S_WAIT && fin_s) begin
                add_req   <= 1'b0;
                out_valid <= 1'b1;
                out_id    <= cur_id;
                out_sum   <= add_so;
                out_cout  <= add_couto;
`ifdef ADD_ARB_TIMEOUT_EN
                out_err   <= 1'b0;
`endif
            end
`ifdef ADD_ARB_TIMEOUT_EN
            if (state == S_SETUP) wait_cnt <= '0;
            if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
            if (tmo) begin
                add_req   <= 1'b0;
                out_valid <= 1'b1;
                out_id    <= cur_id;
                out_sum   <= '0;
                out_cout  <= 1'b0;
                out_err   <= 1'b1;
            end
            if (state == S_DONE && out_err) fault <= 1'b1;
`endif
        end
    end

endmodule
